antirrebote_boton: RTL and testbench

Debounce and edge-detect stage for the maintenance push-button. It sits directly upstream of the control FSM and produces its `boton_presionado` input. The block synchronises the raw asynchronous button, filters contact bounce, and emits exactly one single-cycle pulse per confirmed press. It also provides a debounced level, a long-press pulse, and a running press count.

---
 rtl/antirrebote_boton.sv | 133 +++++++++++++
 tb/tb_antirrebote_boton.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/antirrebote_boton.sv
// antirrebote_boton: synchroniser, debounce filter and edge detect
// for the maintenance push-button feeding the control FSM.
module antirrebote_boton #(
  parameter int CICLOS_ESTABLE = 16,
  parameter int CICLOS_LARGO   = 200
) (
  input  logic       reloj,
  input  logic       reset_n,
  input  logic       boton_in,
  output logic       boton_presionado,
  output logic       boton_estable,
  output logic       pulsacion_larga,
  output logic [7:0] cuenta_pulsaciones
);

  typedef enum logic [1:0] {
    REPOSO,
    FILTRO_PRESION,
    PRESIONADO,
    FILTRO_LIBERACION
  } estado_t;

  localparam logic [7:0] UMBRAL = 8'(CICLOS_ESTABLE - 1);
  localparam logic [7:0] LARGO  = 8'(CICLOS_LARGO);

  logic       sync1;
  logic       boton_sync;
  estado_t    estado;
  estado_t    estado_sig;
  logic [7:0] contador;
  logic [7:0] contador_sig;
  logic [7:0] contador_largo;
  logic [7:0] largo_sig;
  logic [7:0] largo_inc;
  logic [7:0] cuenta_sig;
  logic       pres_sig;
  logic       estable_sig;
  logic       larga_sig;
  logic       en_pulsacion;

  // two-flop synchroniser for the asynchronous button
  always_ff @(posedge reloj or negedge reset_n) begin
    if (!reset_n) begin
      sync1      <= 1'b0;
      boton_sync <= 1'b0;
    end else begin
      sync1      <= boton_in;
      boton_sync <= sync1;
    end
  end

  assign en_pulsacion = (estado == PRESIONADO) ||
                        (estado == FILTRO_LIBERACION);
  assign largo_inc    = contador_largo + 8'd1;

  // next state, filter counters and registered output values
  always_comb begin
    estado_sig   = estado;
    contador_sig = contador;
    largo_sig    = contador_largo;
    cuenta_sig   = cuenta_pulsaciones;
    pres_sig     = 1'b0;
    estable_sig  = boton_estable;
    larga_sig    = 1'b0;

    // held time keeps running through release bounce, saturating
    if (en_pulsacion && (contador_largo != LARGO)) begin
      largo_sig = largo_inc;
      larga_sig = (largo_inc == LARGO);
    end

    unique case (estado)
      REPOSO: begin
        if (boton_sync) begin
          estado_sig   = FILTRO_PRESION;
          contador_sig = 8'd1;
        end
      end
      FILTRO_PRESION: begin
        if (!boton_sync) begin
          estado_sig = REPOSO;
        end else if (contador == UMBRAL) begin
          estado_sig  = PRESIONADO;
          pres_sig    = 1'b1;
          estable_sig = 1'b1;
          cuenta_sig  = cuenta_pulsaciones + 8'd1;
          largo_sig   = 8'd0;
        end else begin
          contador_sig = contador + 8'd1;
        end
      end
      PRESIONADO: begin
        if (!boton_sync) begin
          estado_sig   = FILTRO_LIBERACION;
          contador_sig = 8'd1;
        end
      end
      FILTRO_LIBERACION: begin
        if (boton_sync) begin
          estado_sig = PRESIONADO;
        end else if (contador == UMBRAL) begin
          estado_sig  = REPOSO;
          estable_sig = 1'b0;
        end else begin
          contador_sig = contador + 8'd1;
        end
      end
      default: estado_sig = REPOSO;
    endcase
  end

  // state, counters and all outputs are registered
  always_ff @(posedge reloj or negedge reset_n) begin
    if (!reset_n) begin
      estado             <= REPOSO;
      contador           <= 8'd0;
      contador_largo     <= 8'd0;
      boton_presionado   <= 1'b0;
      boton_estable      <= 1'b0;
      pulsacion_larga    <= 1'b0;
      cuenta_pulsaciones <= 8'd0;
    end else begin
      estado             <= estado_sig;
      contador           <= contador_sig;
      contador_largo     <= largo_sig;
      boton_presionado   <= pres_sig;
      boton_estable      <= estable_sig;
      pulsacion_larga    <= larga_sig;
      cuenta_pulsaciones <= cuenta_sig;
    end
  end

endmodule

// File: tb/tb_antirrebote_boton.sv
// tb_antirrebote_boton: randomized and directed checks of the
// button debouncer against a run-length behavioural model.
module tb_antirrebote_boton;

  localparam int CE = 4;
  localparam int CL = 10;

  logic       reloj;
  logic       reset_n;
  logic       boton_in;
  logic       boton_presionado;
  logic       boton_estable;
  logic       pulsacion_larga;
  logic [7:0] cuenta_pulsaciones;

  int total;
  int bad;

  logic       m_h0;
  logic       m_h1;
  logic       m_d;
  logic       e_pres;
  logic       e_larga;
  logic [7:0] m_cnt;
  int         m_run;
  int         m_since;

  logic [10:0] obs;
  logic [10:0] want;

  assign obs  = {boton_presionado, boton_estable,
                 pulsacion_larga, cuenta_pulsaciones};
  assign want = {e_pres, m_d, e_larga, m_cnt};

  antirrebote_boton #(
    .CICLOS_ESTABLE(CE),
    .CICLOS_LARGO  (CL)
  ) dut (
    .reloj             (reloj),
    .reset_n           (reset_n),
    .boton_in          (boton_in),
    .boton_presionado  (boton_presionado),
    .boton_estable     (boton_estable),
    .pulsacion_larga   (pulsacion_larga),
    .cuenta_pulsaciones(cuenta_pulsaciones)
  );

  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  task automatic model_reset();
    m_h0    = 1'b0;
    m_h1    = 1'b0;
    m_d     = 1'b0;
    e_pres  = 1'b0;
    e_larga = 1'b0;
    m_cnt   = 8'd0;
    m_run   = 0;
    m_since = 0;
  endtask

  // Level flips once CE consecutive synchronised samples disagree
  // with it; held time counts edges spent with the level high.
  task automatic tick(input logic b);
    logic s;
    boton_in = b;
    @(posedge reloj);
    s    = m_h1;
    m_h1 = m_h0;
    m_h0 = b;
    e_pres  = 1'b0;
    e_larga = 1'b0;
    if (m_d && m_since < CL) begin
      m_since++;
      if (m_since == CL) e_larga = 1'b1;
    end
    if (s != m_d) m_run++;
    else m_run = 0;
    if (m_run == CE) begin
      m_run = 0;
      m_d   = s;
      if (s) begin
        e_pres  = 1'b1;
        m_cnt   = m_cnt + 8'd1;
        m_since = 0;
      end
    end
    #1;
  endtask

  // asynchronous reset between edges, released before next edge
  task automatic pulse_reset();
    #3;
    reset_n = 1'b0;
    model_reset();
    #3;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    boton_in = 1'b1;
    model_reset();
    repeat (2) @(posedge reloj);
    #1;
    total++;
    if (obs !== 11'd0) begin
      bad++;
      $display("FAIL reset got=%b exp=%b", obs, 11'd0);
    end
    boton_in = 1'b0;
    #3;
    reset_n = 1'b1;
    for (int i = 0; i < CE + 4; i++) begin
      tick(1'b0);
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL reset_idle i=%0d got=%b exp=%b",
                 i, obs, want);
      end
    end
  endtask

  task automatic test_clean_press();
    int first;
    first = -1;
    for (int i = 0; i < 12; i++) begin
      tick(1'b1);
      if (boton_presionado && first < 0) first = i;
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL clean i=%0d got=%b exp=%b", i, obs, want);
      end
    end
    total++;
    if (first !== CE + 1) begin
      bad++;
      $display("FAIL clean_lat got=%0d exp=%0d", first, CE + 1);
    end
    total++;
    if ({boton_estable, cuenta_pulsaciones} !== 9'h101) begin
      bad++;
      $display("FAIL clean_lvl got=%b/%0d exp=1/1",
               boton_estable, cuenta_pulsaciones);
    end
    first = -1;
    for (int i = 0; i < CE + 4; i++) begin
      tick(1'b0);
      if (!boton_estable && first < 0) first = i;
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL clean_rel i=%0d got=%b exp=%b",
                 i, obs, want);
      end
    end
    total++;
    if (first !== CE + 1) begin
      bad++;
      $display("FAIL release_lat got=%0d exp=%0d", first, CE + 1);
    end
  endtask

  task automatic test_bouncy_press();
    logic [7:0] c0;
    int n;
    int at;
    logic [3:0] pat;
    pat = 4'b0101;
    c0 = m_cnt;
    n  = 0;
    at = -1;
    for (int i = 0; i < 4; i++) begin
      tick(pat[i]);
      if (boton_presionado) n++;
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL bouncy i=%0d got=%b exp=%b", i, obs, want);
      end
    end
    for (int i = 0; i < 12; i++) begin
      tick(1'b1);
      if (boton_presionado) begin
        n++;
        at = i;
      end
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL bouncy_h i=%0d got=%b exp=%b", i, obs, want);
      end
    end
    total++;
    if (n !== 1 || at !== CE + 1) begin
      bad++;
      $display("FAIL bouncy_pulse got=%0d@%0d exp=1@%0d",
               n, at, CE + 1);
    end
    total++;
    if (cuenta_pulsaciones !== c0 + 8'd1) begin
      bad++;
      $display("FAIL bouncy_cnt got=%0d exp=%0d",
               cuenta_pulsaciones, c0 + 8'd1);
    end
    for (int i = 0; i < CE + 4; i++) tick(1'b0);
  endtask

  task automatic test_release_bounce();
    logic [7:0] c0;
    int n;
    int low;
    for (int i = 0; i < CE + 3; i++) tick(1'b1);
    c0  = m_cnt;
    n   = 0;
    low = 0;
    for (int i = 0; i < 8; i++) begin
      tick((i == 0 || i == 1) ? 1'b0 : 1'b1);
      if (boton_presionado) n++;
      if (!boton_estable) low++;
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL rel_bounce i=%0d got=%b exp=%b",
                 i, obs, want);
      end
    end
    total++;
    if (n !== 0 || low !== 0 || cuenta_pulsaciones !== c0) begin
      bad++;
      $display("FAIL rel_glitch got=%0d/%0d/%0d exp=0/0/%0d",
               n, low, cuenta_pulsaciones, c0);
    end
    for (int i = 0; i < CE + 4; i++) tick(1'b0);
  endtask

  task automatic test_long_press();
    int p;
    int q;
    int n;
    p = -1;
    q = -1;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      tick(1'b1);
      if (boton_presionado) p = i;
      if (pulsacion_larga) begin
        n++;
        q = i;
      end
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL long i=%0d got=%b exp=%b", i, obs, want);
      end
    end
    total++;
    if (n !== 1 || q - p !== CL) begin
      bad++;
      $display("FAIL long_pulse got=%0d gap=%0d exp=1 gap=%0d",
               n, q - p, CL);
    end
    for (int i = 0; i < CE + 4; i++) tick(1'b0);
    n = 0;
    for (int i = 0; i < 2 * CE + 11; i++) begin
      tick(i < CE + 5 ? 1'b1 : 1'b0);
      if (pulsacion_larga) n++;
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL short i=%0d got=%b exp=%b", i, obs, want);
      end
    end
    total++;
    if (n !== 0) begin
      bad++;
      $display("FAIL short_long got=%0d exp=0", n);
    end
  endtask

  task automatic test_wrap();
    pulse_reset();
    for (int k = 0; k < 257; k++) begin
      for (int i = 0; i < 2 * CE + 6; i++) begin
        tick(i < CE + 3 ? 1'b1 : 1'b0);
        total++;
        if (obs !== want) begin
          bad++;
          $display("FAIL wrap k=%0d i=%0d got=%b exp=%b",
                   k, i, obs, want);
        end
      end
      if (k == 255) begin
        total++;
        if (cuenta_pulsaciones !== 8'd0) begin
          bad++;
          $display("FAIL wrap256 got=%0d exp=0", cuenta_pulsaciones);
        end
      end
    end
    total++;
    if (cuenta_pulsaciones !== 8'd1) begin
      bad++;
      $display("FAIL wrap257 got=%0d exp=1", cuenta_pulsaciones);
    end
  endtask

  task automatic test_async_reset();
    int at;
    for (int i = 0; i < 3; i++) tick(1'b1);
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (obs !== 11'd0) begin
      bad++;
      $display("FAIL async_filt got=%b exp=%b", obs, 11'd0);
    end
    #3;
    reset_n = 1'b1;
    at = -1;
    for (int i = 0; i < 12; i++) begin
      tick(1'b1);
      if (boton_presionado && at < 0) at = i;
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL async_hold i=%0d got=%b exp=%b",
                 i, obs, want);
      end
    end
    total++;
    if (at !== CE + 1) begin
      bad++;
      $display("FAIL async_lat got=%0d exp=%0d", at, CE + 1);
    end
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (obs !== 11'd0) begin
      bad++;
      $display("FAIL async_held got=%b exp=%b", obs, 11'd0);
    end
    boton_in = 1'b0;
    #3;
    reset_n = 1'b1;
    for (int i = 0; i < CL + 6; i++) begin
      tick(1'b0);
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL async_idle i=%0d got=%b exp=%b",
                 i, obs, want);
      end
    end
  endtask

  task automatic test_random();
    logic b;
    int run;
    b   = 1'b0;
    run = 0;
    for (int i = 0; i < 1500; i++) begin
      if (run == 0) begin
        b   = ~b;
        run = int'($urandom_range(1, 3 * CE + 4));
      end
      run--;
      tick(b);
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL random i=%0d got=%b exp=%b", i, obs, want);
      end
      total++;
      if (boton_presionado && pulsacion_larga) begin
        bad++;
        $display("FAIL exclusive i=%0d got=11 exp=not both", i);
      end
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset_n  = 1'b0;
    boton_in = 1'b0;
    test_reset();
    test_clean_press();
    test_bouncy_press();
    test_release_bounce();
    test_long_press();
    test_wrap();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
